mmio_bus_ctrl: RTL

//  Parametrised memory-mapped bus for the CPU data port. Decodes one address/load/in/out port into
//  an internal data RAM (address[13]=0) and an IO register page (address[13]=1), selected by address[3:0].

---
 rtl/mmio_bus_ctrl.sv | 95 +++++++++
 1 files changed

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: CPU data-port decoder for an internal RAM plus an IO page of debounced buttons,
// sticky press flags, an LED register and a free-running tick counter.
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   address  CPU data address; [13]=0 selects RAM, [13]=1 selects IO register [3:0]
//   load     write strobe, write lands at the rising edge
//   in       write data
//   out      combinational read data for address
//   btn      raw asynchronous button levels, active-high
//   led      LED drive, mirrors the LED register
module mmio_bus_ctrl #(
   parameter int DATA_W          = 16,
   parameter int RAM_AW          = 13,
   parameter int N_BTN           = 4,
   parameter int N_LED           = 8,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       address,
   input  logic              load,
   input  logic [DATA_W-1:0] in,
   output logic [DATA_W-1:0] out,
   input  logic [N_BTN-1:0]  btn,
   output logic [N_LED-1:0]  led
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);
   logic [DATA_W-1:0] ram_q [2**RAM_AW];
   logic [N_BTN-1:0]  sync1_q, sync2_q, stable_q, stable_d, edge_q, edge_d, clr;
   logic [CW-1:0]     cnt_q [N_BTN];
   logic [CW-1:0]     cnt_d [N_BTN];
   logic [N_LED-1:0]  led_q, led_d;
   logic [DATA_W-1:0] tick_q, tick_d, io_rd;
   logic [3:0]        reg_sel;
   logic              io_sel, ram_we, wr_led, wr_edge, wr_tick;
   // Address bits outside the decoded fields alias by design.
   logic              unused_addr;
   assign unused_addr = ^address;
   assign led = led_q;
   always_comb begin
      io_sel   = address[13];
      reg_sel  = address[3:0];
      ram_we   = load && !io_sel;
      wr_led   = load && io_sel && reg_sel == 4'd1;
      wr_edge  = load && io_sel && reg_sel == 4'd2;
      wr_tick  = load && io_sel && reg_sel == 4'd3;
      clr      = wr_edge ? in[N_BTN-1:0] : '0;
      led_d    = wr_led ? in[N_LED-1:0] : led_q;
      tick_d   = wr_tick ? in : tick_q + 1'b1;
      stable_d = stable_q;
      // A level is accepted only after the synced input has disagreed with
      // the stable value for DEBOUNCE_CYCLES consecutive cycles.
      for (int i = 0; i < N_BTN; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            cnt_d[i]    = cnt_q[i] == CNT_TERM ? '0 : cnt_q[i] + 1'b1;
            stable_d[i] = cnt_q[i] == CNT_TERM ? sync2_q[i] : stable_q[i];
         end
      end
      // A new rising edge beats a simultaneous W1C clear.
      edge_d = (edge_q & ~clr) | (stable_d & ~stable_q);
      io_rd  = reg_sel == 4'd0 ? DATA_W'(stable_q)
             : reg_sel == 4'd1 ? DATA_W'(led_q)
             : reg_sel == 4'd2 ? DATA_W'(edge_q)
             : reg_sel == 4'd3 ? tick_q : '0;
      out    = io_sel ? io_rd : ram_q[address[RAM_AW-1:0]];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         edge_q   <= '0;
         cnt_q    <= '{default: '0};
         led_q    <= '0;
         tick_q   <= '0;
      end else begin
         sync1_q  <= btn;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         edge_q   <= edge_d;
         cnt_q    <= cnt_d;
         led_q    <= led_d;
         tick_q   <= tick_d;
      end
   end
   // RAM keeps its contents through reset but ignores writes while reset is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
      end else if (ram_we) begin
         ram_q[address[RAM_AW-1:0]] <= in;
      end
   end
endmodule
